// File: rtl/softmax_max_norm_stream.sv
// Softmax front end: buffers a row of input beats while reducing per-segment maxima,
// then replays the row as saturated (x - max) alongside the broadcast segment maxima.
module softmax_max_norm_stream #(
    parameter int LANES     = 64,
    parameter int W         = 16,
    parameter int MAX_BEATS = 4,
    localparam int LOG_LANES = $clog2(LANES),
    localparam int BW        = $clog2(MAX_BEATS) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [LOG_LANES:0]   seg_log2,
    input  logic [BW-1:0]        row_beats,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_flat,
    output logic [LANES*W-1:0]   out_max_flat,
    output logic                 out_last
);
    localparam int SW = LOG_LANES + 1;
    localparam int IW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [SW-1:0] SEG_TOP   = SW'(LOG_LANES);
    localparam logic [BW-1:0] BEATS_TOP = BW'(MAX_BEATS);
    localparam logic [BW-1:0] ONE_BEAT  = BW'(1);
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [0:0] ACCUM  = 1'b0;
    localparam logic [0:0] REPLAY = 1'b1;

    logic [0:0]          state;
    logic [BW-1:0]       beat_cnt;
    logic [BW-1:0]       beats_lat;
    logic [SW-1:0]       seg_lat;
    logic signed [W-1:0] run_max [LANES];
    logic [LANES*W-1:0]  buffer [1<<IW];

    logic [SW-1:0]       seg_in, cur_seg, eff_seg;
    logic [BW-1:0]       beats_in, cur_beats;
    logic                first_beat, last_in;
    logic signed [W-1:0] tree [SW][LANES];
    logic signed [W-1:0] seg_max [LANES];
    logic signed [W-1:0] next_max [LANES];
    logic [LANES*W-1:0]  src_beat, norm_flat, max_flat;
    logic signed [W-1:0] x, m;
    logic signed [W:0]   diff;

    assign in_ready   = en && (state == ACCUM);
    assign first_beat = (beat_cnt == '0);

    // Row parameters come straight from the ports on a row's first beat, from the latches afterwards.
    always_comb begin
        seg_in = (seg_log2 > SEG_TOP) ? SEG_TOP : seg_log2;
        if (row_beats == '0)
            beats_in = ONE_BEAT;
        else if (row_beats > BEATS_TOP)
            beats_in = BEATS_TOP;
        else
            beats_in = row_beats;
        cur_seg   = first_beat ? seg_in : seg_lat;
        cur_beats = first_beat ? beats_in : beats_lat;
        eff_seg   = (cur_beats == ONE_BEAT) ? cur_seg : SEG_TOP;
        last_in   = (beat_cnt == cur_beats - ONE_BEAT);
    end

    // Butterfly: level j leaves every lane holding the max of its aligned 2^j-lane group.
    always_comb begin
        for (int i = 0; i < LANES; i++)
            tree[0][i] = $signed(in_flat[i*W +: W]);
        for (int j = 1; j < SW; j++) begin
            for (int i = 0; i < LANES; i++) begin
                tree[j][i] = (tree[j-1][i] > tree[j-1][i ^ (1 << (j-1))])
                           ? tree[j-1][i] : tree[j-1][i ^ (1 << (j-1))];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            seg_max[i] = tree[0][i];
            for (int j = 1; j < SW; j++)
                if (eff_seg == SW'(j))
                    seg_max[i] = tree[j][i];
            next_max[i] = (first_beat || (seg_max[i] > run_max[i])) ? seg_max[i] : run_max[i];
        end
    end

    // Beat 0 of a single-beat row is still on the input bus when its output is registered.
    always_comb begin
        norm_flat = '0;
        max_flat  = '0;
        x         = '0;
        m         = '0;
        diff      = '0;
        if (state == ACCUM)
            src_beat = first_beat ? in_flat : buffer[0];
        else
            src_beat = buffer[IW'(beat_cnt + ONE_BEAT)];
        for (int i = 0; i < LANES; i++) begin
            m    = (state == ACCUM) ? next_max[i] : run_max[i];
            x    = $signed(src_beat[i*W +: W]);
            diff = {x[W-1], x} - {m[W-1], m};
            if (diff[W] != diff[W-1])
                norm_flat[i*W +: W] = diff[W] ? MIN_VAL : MAX_VAL;
            else
                norm_flat[i*W +: W] = diff[W-1:0];
            max_flat[i*W +: W] = m;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid)
            buffer[beat_cnt[IW-1:0]] <= in_flat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ACCUM;
            beat_cnt     <= '0;
            beats_lat    <= '0;
            seg_lat      <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_flat     <= '0;
            out_max_flat <= '0;
            for (int i = 0; i < LANES; i++)
                run_max[i] <= MIN_VAL;
        end else if (en) begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (first_beat) begin
                            seg_lat   <= seg_in;
                            beats_lat <= beats_in;
                        end
                        for (int i = 0; i < LANES; i++)
                            run_max[i] <= next_max[i];
                        if (last_in) begin
                            state        <= REPLAY;
                            beat_cnt     <= '0;
                            out_valid    <= 1'b1;
                            out_last     <= (cur_beats == ONE_BEAT);
                            out_flat     <= norm_flat;
                            out_max_flat <= max_flat;
                        end else begin
                            beat_cnt <= beat_cnt + ONE_BEAT;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= ACCUM;
                            beat_cnt  <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            for (int i = 0; i < LANES; i++)
                                run_max[i] <= MIN_VAL;
                        end else begin
                            beat_cnt <= beat_cnt + ONE_BEAT;
                            out_last <= ((beat_cnt + ONE_BEAT) == (beats_lat - ONE_BEAT));
                            out_flat <= norm_flat;
                        end
                    end
                end
            endcase
        end
    end
endmodule
